// File: rtl/gtxe2_chnl_tx_comma_insert.sv
// rtl/gtxe2_chnl_tx_comma_insert.sv - TX comma framer with init/periodic/idle comma insertion and programmable bit-slip
module gtxe2_chnl_tx_comma_insert #(
    parameter int         width              = 20,
    parameter logic [9:0] ALIGN_PCOMMA_VALUE = 10'b0101111100,
    parameter logic [9:0] ALIGN_MCOMMA_VALUE = 10'b1010000011,
    parameter int         INIT_BURST         = 16,
    parameter int         COMMA_PERIOD       = 256,
    parameter int         COMMA_BURST        = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [width-1:0]          indata,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      TXCOMMAEN,
    input  logic                      TXSLIDE,
    output logic [width-1:0]          outdata,
    output logic [$clog2(width)-1:0]  slide_offset,
    output logic                      TXCOMMASENT,
    output logic                      TXALIGNED
);

    localparam int OW   = $clog2(width);
    localparam int SW   = $clog2(2 * width);
    localparam int BMAX = (INIT_BURST > COMMA_BURST) ? INIT_BURST : COMMA_BURST;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int PW   = $clog2(COMMA_PERIOD + 1);

    localparam logic [BW-1:0] INIT_LAST   = BW'(INIT_BURST - 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(COMMA_BURST - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(COMMA_PERIOD - 1);
    localparam logic [OW-1:0] OFFSET_LAST = OW'(width - 1);

    // Plus-comma in the first transmitted symbol, alternating polarity above it.
    function automatic logic [width-1:0] gen_comma();
        logic [width-1:0] w;
        w = '0;
        for (int s = 0; s < width / 10; s++) begin
            w[s*10 +: 10] = (s % 2 == 0) ? ALIGN_PCOMMA_VALUE : ALIGN_MCOMMA_VALUE;
        end
        return w;
    endfunction

    localparam logic [width-1:0] COMMA = gen_comma();

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t            state;
    logic [BW-1:0]     burst_cnt;
    logic [PW-1:0]     period_cnt;
    logic [width-1:0]  word_r;
    logic [width-1:0]  word_prev;
    logic              en_d;
    logic              accept;
    logic [2*width-1:0] data_cat;
    logic [SW-1:0]     shamt;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            burst_cnt    <= '0;
            period_cnt   <= '0;
            word_r       <= '0;
            word_prev    <= '0;
            slide_offset <= '0;
            in_ready     <= 1'b0;
            TXCOMMASENT  <= 1'b0;
            TXALIGNED    <= 1'b0;
            en_d         <= 1'b1;
        end else begin
            word_prev <= word_r;
            en_d      <= TXCOMMAEN;

            if (TXSLIDE) begin
                slide_offset <= (slide_offset == OFFSET_LAST) ? '0 : slide_offset + 1'b1;
            end

            if (!TXCOMMAEN) begin
                state       <= ST_DATA;
                burst_cnt   <= '0;
                period_cnt  <= '0;
                in_ready    <= 1'b1;
                TXCOMMASENT <= 1'b0;
                word_r      <= accept ? indata : '0;
            end else begin
                unique case (state)
                    ST_INIT: begin
                        word_r      <= COMMA;
                        TXCOMMASENT <= 1'b1;
                        if (burst_cnt == INIT_LAST) begin
                            state     <= ST_DATA;
                            burst_cnt <= '0;
                            in_ready  <= 1'b1;
                            TXALIGNED <= 1'b1;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            word_r      <= indata;
                            TXCOMMASENT <= 1'b0;
                            if (period_cnt == PERIOD_LAST) begin
                                state      <= ST_BURST;
                                period_cnt <= '0;
                                in_ready   <= 1'b0;
                            end else begin
                                period_cnt <= period_cnt + 1'b1;
                                in_ready   <= 1'b1;
                            end
                        end else begin
                            word_r      <= COMMA;
                            TXCOMMASENT <= 1'b1;
                            in_ready    <= 1'b1;
                        end
                    end
                    ST_BURST: begin
                        word_r      <= COMMA;
                        TXCOMMASENT <= 1'b1;
                        if (burst_cnt == BURST_LAST) begin
                            state     <= ST_DATA;
                            burst_cnt <= '0;
                            in_ready  <= 1'b1;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= ST_INIT;
                        burst_cnt   <= '0;
                        in_ready    <= 1'b0;
                        TXCOMMASENT <= 1'b0;
                    end
                endcase

                // First enabled cycle after pass-through: the word of this edge follows
                // the handshake already offered, then a fresh init burst begins.
                if (!en_d) begin
                    state      <= ST_INIT;
                    burst_cnt  <= '0;
                    period_cnt <= '0;
                    in_ready   <= 1'b0;
                    TXALIGNED  <= 1'b0;
                end
            end
        end
    end

    // Offset k selects data[width-k +: width], delaying the stream by k bits.
    assign data_cat = {word_r, word_prev};
    assign shamt    = SW'(width) - SW'(slide_offset);
    assign outdata  = data_cat[shamt +: width];

endmodule

// File: tb/tb_gtxe2_chnl_tx_comma_insert.sv
// tb/tb_gtxe2_chnl_tx_comma_insert.sv - self-checking bench for gtxe2_chnl_tx_comma_insert
module tb_gtxe2_chnl_tx_comma_insert;

    localparam int W = 20;
    localparam logic [9:0]   P_SYM = 10'b0101111100;
    localparam logic [9:0]   M_SYM = 10'b1010000011;
    localparam logic [W-1:0] COMMA = {M_SYM, P_SYM};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] indata;
    logic         in_valid;
    logic         in_ready;
    logic         TXCOMMAEN;
    logic         TXSLIDE;
    logic [W-1:0] outdata;
    logic [4:0]   slide_offset;
    logic         TXCOMMASENT;
    logic         TXALIGNED;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] seq;
    logic [W-1:0] data_q[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         sl;
        int           exp_k;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t tbl[23];

    gtxe2_chnl_tx_comma_insert dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .indata       (indata),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .TXCOMMAEN    (TXCOMMAEN),
        .TXSLIDE      (TXSLIDE),
        .outdata      (outdata),
        .slide_offset (slide_offset),
        .TXCOMMASENT  (TXCOMMASENT),
        .TXALIGNED    (TXALIGNED)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic v, input logic [W-1:0] d, input logic en, input logic sl);
        in_valid  = v;
        indata    = d;
        TXCOMMAEN = en;
        TXSLIDE   = sl;
        @(posedge clk);
        #1;
    endtask

    // Bit i of the slipped output comes from prev when i < k, else from cur shifted up by k.
    function automatic logic [W-1:0] window(input logic [W-1:0] cur, input logic [W-1:0] prev, input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (i < k) r[i] = prev[W - k + i];
            else       r[i] = cur[i - k];
        end
        return r;
    endfunction

    task automatic init_burst();
        chk("rdy_init_pre", in_ready, 0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, seq, 1'b1, 1'b0);
            chk("init_comma", outdata, COMMA);
            chk("init_sent", TXCOMMASENT, 1);
            chk("init_rdy", in_ready, (i == 15));
            chk("init_aligned", TXALIGNED, (i == 15));
        end
    endtask

    task automatic data_words(input int n, input int idle_at);
        int acc;
        int cyc;
        logic idle;
        logic [W-1:0] e;
        acc = 0;
        cyc = 0;
        while (acc < n) begin
            idle = (idle_at >= 0) && (cyc >= idle_at) && (cyc < idle_at + 3);
            chk("rdy_data", in_ready, 1);
            if (!idle) data_q.push_back(seq);
            tick(!idle, seq, 1'b1, 1'b0);
            if (idle) begin
                chk("idle_comma", outdata, COMMA);
                chk("idle_sent", TXCOMMASENT, 1);
            end else begin
                e = data_q.pop_front();
                chk("data_word", outdata, e);
                chk("data_sent", TXCOMMASENT, 0);
                seq = seq + 1'b1;
                acc++;
            end
            cyc++;
        end
    endtask

    task automatic burst_words(input int n);
        for (int j = 0; j < n; j++) begin
            chk("rdy_burst", in_ready, 0);
            tick(1'b1, seq, 1'b1, 1'b0);
            chk("burst_comma", outdata, COMMA);
            chk("burst_sent", TXCOMMASENT, 1);
        end
    endtask

    initial begin
        int k;
        logic [W-1:0] cur;
        logic [W-1:0] prev;
        logic [W-1:0] e;

        // Slip table in pass-through mode: expected offset and output derived from the loaded words.
        k = 0;
        cur = '0;
        prev = '0;
        for (int r = 0; r < 23; r++) begin
            tbl[r].v  = 1'b1;
            tbl[r].sl = 1'b1;
            tbl[r].d  = W'($urandom);
            case (r)
                0: begin tbl[r].d = 20'hA5A5A; tbl[r].sl = 1'b0; end
                1: tbl[r].d = 20'h3C3C3;
                2: tbl[r].d = 20'h0F0F0;
                3: tbl[r].d = COMMA;
                4: begin tbl[r].d = COMMA; tbl[r].sl = 1'b0; end
                5: begin tbl[r].v = 1'b0; tbl[r].sl = 1'b0; end
                default: ;
            endcase
            prev = cur;
            cur  = tbl[r].v ? tbl[r].d : '0;
            if (tbl[r].sl) k = (k == W - 1) ? 0 : k + 1;
            tbl[r].exp_k   = k;
            tbl[r].exp_out = window(cur, prev, k);
        end

        seq       = 20'h00100;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        indata    = seq;
        TXCOMMAEN = 1'b1;
        TXSLIDE   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", outdata, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_sent", TXCOMMASENT, 0);
        chk("rst_aligned", TXALIGNED, 0);
        chk("rst_offset", slide_offset, 0);
        rst_n = 1'b1;

        init_burst();

        // 256 data words with a 3-cycle idle gap, periodic burst, then seamless resume.
        data_words(256, 50);
        burst_words(4);
        data_words(1, -1);
        data_words(255, -1);
        burst_words(2);

        // Drop framing mid-burst, pass-through with zero fill, then re-enable.
        tick(1'b1, 20'h12345, 1'b0, 1'b0);
        chk("pt_rdy", in_ready, 1);
        chk("pt_first_zero", outdata, 0);
        chk("pt_sent", TXCOMMASENT, 0);
        chk("pt_aligned_hold", TXALIGNED, 1);
        tick(1'b1, 20'h12345, 1'b0, 1'b0);
        chk("pt_word1", outdata, 20'h12345);
        tick(1'b0, 20'h55555, 1'b0, 1'b0);
        chk("pt_idle_zero", outdata, 0);
        chk("pt_idle_sent", TXCOMMASENT, 0);
        tick(1'b1, 20'h6789A, 1'b0, 1'b0);
        chk("pt_word2", outdata, 20'h6789A);
        tick(1'b0, 20'h0, 1'b1, 1'b0);
        chk("reen_aligned", TXALIGNED, 0);
        chk("reen_rdy", in_ready, 0);
        init_burst();
        data_words(2, -1);

        // Bit-slip table.
        tick(1'b0, 20'h0, 1'b0, 1'b0);
        for (int r = 0; r < 23; r++) begin
            tick(tbl[r].v, tbl[r].d, 1'b0, tbl[r].sl);
            chk("slip_offset", slide_offset, tbl[r].exp_k);
            chk("slip_out", outdata, tbl[r].exp_out);
            chk("slip_rdy", in_ready, 1);
            if (r == 4) begin
                chk("slip_comma_at_3", outdata[12:3], P_SYM);
                chk("slip_low_bits", outdata[2:0], COMMA[19:17]);
            end
        end
        chk("slip_wrapped", slide_offset, 0);

        // Asynchronous reset in the middle of data.
        tick(1'b0, 20'h0, 1'b1, 1'b0);
        chk("reen2_aligned", TXALIGNED, 0);
        init_burst();
        data_words(1, -1);
        data_q.push_back(seq);
        tick(1'b1, seq, 1'b1, 1'b1);
        e = data_q.pop_front();
        chk("slide_data_out", outdata, window(e, e - 1'b1, 1));
        chk("pre_rst_offset", slide_offset, 1);
        seq = seq + 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out", outdata, 0);
        chk("async_rdy", in_ready, 0);
        chk("async_sent", TXCOMMASENT, 0);
        chk("async_aligned", TXALIGNED, 0);
        chk("async_offset", slide_offset, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", outdata, 0);
        rst_n = 1'b1;
        init_burst();
        chk("post_rst_offset", slide_offset, 0);
        data_words(3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gtxe2_chnl_tx_comma_insert.md
Name: gtxe2_chnl_tx_comma_insert

Overview:
TX-side counterpart of the channel's RX comma aligner. It sits between the TX user data path and the serializer model. It frames a 10b-encoded word stream by sending an initial comma burst, periodic comma bursts and idle-fill commas, which gives the far-end RX aligner something to lock on. A programmable bit-slip rotates the outgoing stream by 0..width-1 bits so benches can drive the RX aligner with deliberately misaligned data.

Parameters:
width, 20, datapath width in bits (multiple of 10; LSB transmitted first)
ALIGN_PCOMMA_VALUE, 10'b0101111100, plus-comma symbol
ALIGN_MCOMMA_VALUE, 10'b1010000011, minus-comma symbol
INIT_BURST, 16, comma words sent after reset or after TXCOMMAEN rises
COMMA_PERIOD, 256, data words between periodic bursts (>=1)
COMMA_BURST, 4, comma words per periodic burst (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
indata  input  width  encoded user data word
in_valid  input  1  indata valid
in_ready  output  1  word accepted when in_valid & in_ready at posedge
TXCOMMAEN  input  1  enables framing (init, periodic and idle commas)
TXSLIDE  input  1  each high cycle advances the bit-slip offset by 1
outdata  output  width  stream to the serializer
slide_offset  output  clog2(width)  current bit-slip offset
TXCOMMASENT  output  1  high in the cycle a comma word is loaded into the output register
TXALIGNED  output  1  high once the init burst has completed

Behaviour:
- Reset (rst_n low, asynchronous): state=INIT, burst counter=0, period counter=0, word_r=0, word_prev=0, slide_offset=0, in_ready=0, TXCOMMASENT=0, TXALIGNED=0, outdata=0. Assertion mid-operation clears everything immediately. After release, the block restarts with INIT.
- Comma word C = {ALIGN_MCOMMA_VALUE, ALIGN_PCOMMA_VALUE} repeated width/10 symbols, P symbol in bits [9:0] and alternating P/M above.
- State machine (evaluated only when TXCOMMAEN=1):
  - INIT: in_ready=0; loads C each cycle for INIT_BURST cycles, then goes to DATA and sets TXALIGNED=1.
  - DATA: in_ready=1.
    - Accepted word: loaded, period counter +1. On the accept that makes the count COMMA_PERIOD, go to BURST and clear the counter.
    - in_valid=0: loads C as idle fill; counter unchanged.
  - BURST: in_ready=0; loads C for COMMA_BURST cycles, then returns to DATA.
- TXCOMMAEN=0 (pass-through):
  - State is forced to DATA and counters are held at 0; in_ready=1.
  - Valid word: loaded. Invalid cycle: loads all-zero. TXCOMMASENT=0. TXALIGNED holds its value.
- TXCOMMAEN 0->1: go to INIT (a new init burst) and clear TXALIGNED at the next edge. Deasserting during INIT/BURST aborts the burst.
- in_ready is a registered function of the next state: combinational in_valid->in_ready paths are forbidden.
- Output register stage: on each posedge, word_prev<=word_r and word_r<=selected word. data={word_r, word_prev}; outdata[i]=data[width-k+i], where k=slide_offset.
  - k=0: outdata=word_r, one cycle after acceptance.
  - k>0: the upper k bits of word_prev fill the LSBs, i.e. the stream is delayed by k bits.
- slide_offset: +1 per TXSLIDE-high cycle, wraps width-1 -> 0. A change takes effect on outdata in the same cycle as the new offset value.
- TXSLIDE is independent of the state machine and is honoured in all states.

Test Plan:
- Reset release with TXCOMMAEN=1 and in_valid=1 -> in_ready=0 for 16 cycles; outdata=C for 16 consecutive cycles with TXCOMMASENT=1; TXALIGNED rises after the 16th; the first data word appears on outdata the cycle after acceptance.
- Continuous valid incrementing data after init -> exactly 256 data words, then 4 C words (in_ready=0 for 4 cycles), then data resumes with the next sequence value with none lost or duplicated.
- in_valid dropped for 3 cycles in DATA -> 3 idle C words; the period counter is unchanged (burst still occurs after 256 total data words).
- TXSLIDE pulsed 3 times with width=20 -> slide_offset=3. outdata=data[36:17] of {word_r, word_prev}: outdata[2:0]=word_prev[19:17], outdata[19:3]=word_r[16:0]. A downstream comma search finds C at bit 3. 20 pulses wrap slide_offset to 0.
- TXCOMMAEN dropped mid-BURST -> in_ready=1 the next cycle and pass-through data with zeros on idle cycles. Reasserting it -> TXALIGNED=0 and a new 16-word init burst.
- rst_n pulsed low mid-DATA -> all outputs 0 asynchronously; after release the init burst restarts and slide_offset=0.
